// File: rtl/sram_responder_pkg.sv
// Shared SRAM request/response widths, default base address and the clear FSM
// state type used by sram_responder.
package sram_responder_pkg;

  localparam int SRAM_ADDR_WD  = 32;
  localparam int SRAM_WE_WD    = 4;
  localparam int SRAM_WDATA_WD = 32;
  localparam int SRAM_RDATA_WD = 32;
  localparam int SRAM_REQ_WD   = 1 + SRAM_WE_WD + SRAM_ADDR_WD + SRAM_WDATA_WD;

  localparam logic [SRAM_ADDR_WD-1:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

  typedef enum logic {
    SRAM_CLEAR = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != 32'hFFFF_FFFF))
      count <= count + 32'd1;
  end

endmodule

// File: rtl/sram_responder.sv
// Word-organised single-port synchronous RAM responder: one-cycle read latency,
// read-first byte-lane writes, range checking and saturating access counters.
// Optional build macro SRAM_CLEAR_ON_RESET_EN zeroes the array after every reset.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int                        ADDR_W    = 12,
  parameter logic [SRAM_ADDR_WD-1:0]   BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [SRAM_RDATA_WD-1:0]  ERR_RDATA = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [SRAM_WE_WD-1:0]    we,
  input  logic [SRAM_ADDR_WD-1:0]  addr,
  input  logic [SRAM_WDATA_WD-1:0] wdata,
  output logic [SRAM_RDATA_WD-1:0] rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              rd_cnt,
  output logic [31:0]              wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [SRAM_RDATA_WD-1:0] mem [DEPTH];

  logic [SRAM_ADDR_WD-1:0] off;
  logic                    in_range;
  logic [ADDR_W-1:0]       idx;
  logic                    accept;
  logic                    clearing;
  logic [ADDR_W-1:0]       clear_idx;
  logic                    unused_off;

  // Offset wraps at 32 bits, so addresses below BASE_ADDR land far out of range.
  assign off        = addr - BASE_ADDR;
  assign in_range   = (off[SRAM_ADDR_WD-1:ADDR_W+2] == '0);
  assign idx        = off[ADDR_W+1:2];
  assign unused_off = ^off[1:0];
  assign accept     = en && ready && !reset;

`ifdef SRAM_CLEAR_ON_RESET_EN
  sram_state_e state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SRAM_CLEAR;
      clear_idx <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        SRAM_CLEAR: begin
          clear_idx <= clear_idx + ADDR_W'(1);
          if (clear_idx == {ADDR_W{1'b1}}) begin
            state <= SRAM_READY;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign clearing = (state == SRAM_CLEAR) && !reset;
`else
  always_ff @(posedge clk) begin
    if (reset)
      ready <= 1'b0;
    else
      ready <= 1'b1;
  end

  assign clearing  = 1'b0;
  assign clear_idx = '0;
`endif

  // Array has no reset; clearing has priority but never overlaps an accepted access.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clear_idx] <= '0;
    end else if (accept && in_range) begin
      for (int i = 0; i < SRAM_WE_WD; i++) begin
        if (we[i])
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (en && ready) begin
      if (in_range) begin
        rdata <= mem[idx];
      end else begin
        rdata <= ERR_RDATA;
        err   <= 1'b1;
      end
    end
  end

  sat_counter32 u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept && in_range && (we == '0)),
    .count (rd_cnt)
  );

  sat_counter32 u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept && in_range && (we != '0)),
    .count (wr_cnt)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed steps plus random traffic
// checked against a word-array reference model (also builds with SRAM_CLEAR_ON_RESET_EN).
module tb_sram_responder;

  localparam int          AW   = 4;
  localparam int          CAP  = 1 << AW;
  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam logic [31:0] ERRV = 32'hBAD0_BAD0;
`ifdef SRAM_CLEAR_ON_RESET_EN
  localparam int CLEAR_CYCLES = CAP;
`else
  localparam int CLEAR_CYCLES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem [CAP];
  bit          m_known [CAP];
  logic [31:0] e_rdata;
  bit          e_rdata_known;
  bit          e_err;
  bit          e_ready;
  logic [31:0] e_rd;
  logic [31:0] e_wr;
  int          clear_left;

  sram_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .ERR_RDATA(ERRV)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Behavioural effect of one non-reset clock edge
  task automatic modelStep(input bit e, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d);
    logic [31:0] off;
    int          k;
    if (e && e_ready) begin
      off = a - BASE;
      if (off < 32'(CAP * 4)) begin
        k = int'(off / 4);
        e_rdata       = m_mem[k];
        e_rdata_known = m_known[k];
        if (w == 4'h0) begin
          e_rd = satInc(e_rd);
        end else begin
          for (int i = 0; i < 4; i++)
            if (w[i]) m_mem[k][8*i +: 8] = d[8*i +: 8];
          if (w == 4'hF) m_known[k] = 1'b1;
          e_wr = satInc(e_wr);
        end
      end else begin
        e_err = 1'b1;
        if (w == 4'h0) begin
          e_rdata       = ERRV;
          e_rdata_known = 1'b1;
        end else begin
          e_rdata_known = 1'b0;
        end
      end
    end
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) e_ready = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit e, input logic [3:0] w, input logic [31:0] a,
                               input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    modelStep(e, w, a, d);
    #1;
    en = 1'b0; we = 4'h0;
  endtask

  task automatic doReset(input bit e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
    reset = 1'b1; en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    e_rdata = '0; e_rdata_known = 1'b1; e_err = 1'b0;
    e_rd = '0; e_wr = '0; e_ready = 1'b0; clear_left = CLEAR_CYCLES;
`ifdef SRAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < CAP; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b1;
    end
`endif
    #1;
    reset = 1'b0; en = 1'b0; we = 4'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    @(negedge clk);
    checkOutput({tag, ".ready"}, {31'b0, ready}, {31'b0, e_ready});
    checkOutput({tag, ".err"}, {31'b0, err}, {31'b0, e_err});
    checkOutput({tag, ".rd_cnt"}, rd_cnt, e_rd);
    checkOutput({tag, ".wr_cnt"}, wr_cnt, e_wr);
    if (e_rdata_known) checkOutput({tag, ".rdata"}, rdata, e_rdata);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!e_ready && n < CAP + 4) begin
      applyStimulus(1'b0, 4'h0, BASE, 32'h0);
      checkAll(tag);
      n++;
    end
    checkOutput({tag, ".ready_up"}, {31'b0, ready}, 32'd1);
  endtask

  function automatic logic [31:0] wa(input int k);
    return BASE + 32'(4 * k);
  endfunction

  initial begin
    logic [3:0]  rw;
    logic [31:0] ra;
    for (int i = 0; i < CAP; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    e_rdata = '0; e_rdata_known = 1'b0; e_err = 1'b0; e_ready = 1'b0;
    e_rd = '0; e_wr = '0; clear_left = 0;

    @(posedge clk); #1;
    doReset(1'b0, 4'h0, BASE, 32'h0);
    doReset(1'b0, 4'h0, BASE, 32'h0);
    checkAll("reset");

`ifdef SRAM_CLEAR_ON_RESET_EN
    // Restart the clear sequence part-way through, then request during clear
    repeat (7) begin
      applyStimulus(1'b0, 4'h0, BASE, 32'h0);
      checkAll("clear_pre");
    end
    doReset(1'b0, 4'h0, BASE, 32'h0);
    checkAll("clear_restart");
`endif
    applyStimulus(1'b1, 4'h0, BASE, 32'h0);
    checkAll("req_not_ready");
    waitReady("wait_ready");
`ifdef SRAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(1'b1, 4'h0, wa(i), 32'h0);
      checkAll("cleared_word");
    end
`endif

    applyStimulus(1'b1, 4'hF, wa(0), 32'h0000_0013);
    checkAll("wr_w0");
    applyStimulus(1'b1, 4'h0, wa(0), 32'h0);
    checkAll("rd_w0");

    applyStimulus(1'b1, 4'hF, wa(1), 32'h1122_3344);
    checkAll("wr_w1_full");
    applyStimulus(1'b1, 4'b0101, wa(1), 32'hAABB_CCDD);
    checkAll("wr_w1_merge");
    applyStimulus(1'b1, 4'h0, wa(1), 32'h0);
    checkAll("rd_w1_merge");
    checkOutput("merge_value", rdata, 32'h11BB_33DD);

    applyStimulus(1'b1, 4'hF, wa(2), 32'h0101_0101);
    checkAll("wr_w2_init");
    applyStimulus(1'b1, 4'hF, wa(2), 32'hDEAD_BEEF);
    checkAll("wr_w2_readfirst");
    applyStimulus(1'b1, 4'h0, wa(2), 32'h0);
    checkAll("rd_w2_after");

    applyStimulus(1'b1, 4'hF, wa(3), 32'h1234_5678);
    checkAll("wr_w3");
    applyStimulus(1'b1, 4'h0, wa(3), 32'h0);
    checkAll("rd_w3");
    repeat (5) begin
      applyStimulus(1'b0, 4'hF, wa(4), 32'hFFFF_FFFF);
      checkAll("hold_idle");
    end

    applyStimulus(1'b1, 4'h0, 32'h1bff_fffc, 32'h0);
    checkAll("rd_below_base");
    applyStimulus(1'b1, 4'hF, wa(CAP), 32'h5555_5555);
    checkAll("wr_above_top");
    applyStimulus(1'b1, 4'h0, wa(CAP - 1) + 32'd3, 32'h0);
    checkAll("rd_top_word");
    applyStimulus(1'b1, 4'h0, wa(0), 32'h0);
    checkAll("err_sticky");

    // Reset wins over a simultaneous write request
    doReset(1'b1, 4'hF, wa(1), 32'hFFFF_FFFF);
    checkAll("reset_with_req");
    waitReady("wait_ready2");
    applyStimulus(1'b1, 4'h0, wa(1), 32'h0);
    checkAll("rd_after_reset_req");

    for (int t = 0; t < 120; t++) begin
      rw = ($urandom_range(0, 2) == 0) ? 4'h0 :
           ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 9) == 0)
        ra = $urandom;
      else
        ra = wa($urandom_range(0, CAP - 1)) + 32'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 3) != 0, rw, ra, $urandom);
      checkAll("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
